// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared store-size encoding and formatted store entry type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } mem_size_t;

  typedef struct packed {
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        misaligned;
    logic        trunc;
  } st_entry_t;

  localparam int unsigned ENTRY_W = $bits(st_entry_t);

endpackage

`default_nettype wire

// File: rtl/store_lane_fmt.sv
// ============================================================================
// Module   : store_lane_fmt
// Purpose  : Combinational narrowing, lane placement, alignment and
//            truncation check for one store request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_lane_fmt
  import mem_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic [2:0]  addr_i,
  input  logic [63:0] data_i,
  output st_entry_t   entry_o
);

  logic [63:0] narrow_w;
  logic [7:0]  be_base_w;
  logic        mis_w;
  logic        trunc_w;

  always_comb begin
    narrow_w  = data_i;
    be_base_w = 8'hFF;
    mis_w     = 1'b0;
    trunc_w   = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        narrow_w  = {56'd0, data_i[7:0]};
        be_base_w = 8'h01;
        trunc_w   = (data_i[63:8] != {56{data_i[7]}});
      end
      SZ_HALF: begin
        narrow_w  = {48'd0, data_i[15:0]};
        be_base_w = 8'h03;
        mis_w     = addr_i[0];
        trunc_w   = (data_i[63:16] != {48{data_i[15]}});
      end
      SZ_WORD: begin
        narrow_w  = {32'd0, data_i[31:0]};
        be_base_w = 8'h0F;
        mis_w     = |addr_i[1:0];
        trunc_w   = (data_i[63:32] != {32{data_i[31]}});
      end
      default: begin
        mis_w = |addr_i;
      end
    endcase
  end

  // Misaligned stores keep the narrow value unshifted and write no lanes.
  always_comb begin
    entry_o            = '0;
    entry_o.misaligned = mis_w;
    entry_o.trunc      = trunc_w;
    if (mis_w) begin
      entry_o.wdata = narrow_w;
      entry_o.be    = 8'h00;
    end else begin
      entry_o.wdata = narrow_w << {addr_i, 3'b000};
      entry_o.be    = be_base_w << addr_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_formatter.sv
// ============================================================================
// Module   : store_formatter
// Purpose  : Registered store formatter with valid/ready handshake, two-entry
//            skid buffer and saturating fault counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_formatter
  import mem_pkg::*;
#(
  parameter int unsigned FAULT_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  input  logic [1:0]             in_size,
  input  logic [2:0]             in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_wdata,
  output logic [7:0]             out_be,
  output logic                   out_misaligned,
  output logic                   out_trunc,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam logic [FAULT_CNT_W-1:0] FAULT_MAX = {FAULT_CNT_W{1'b1}};

  st_entry_t              fmt_w;
  st_entry_t              main_q, main_d;
  st_entry_t              skid_q, skid_d;
  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [FAULT_CNT_W-1:0] fault_q, fault_d;
  logic                   in_acc_w;
  logic                   out_xfer_w;

  store_lane_fmt u_fmt (
    .size_i  (mem_size_t'(in_size)),
    .addr_i  (in_addr),
    .data_i  (in_data),
    .entry_o (fmt_w)
  );

  assign in_acc_w   = in_valid && !skid_valid_q;
  assign out_xfer_w = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    fault_d      = fault_q;

    // Main register always holds the oldest entry; skid drains first.
    if (!main_valid_q || out_xfer_w) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_acc_w) begin
        main_d       = fmt_w;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_acc_w) begin
      skid_d       = fmt_w;
      skid_valid_d = 1'b1;
    end

    if (out_xfer_w && (main_q.misaligned || main_q.trunc) && (fault_q != FAULT_MAX)) begin
      fault_d = fault_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      fault_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign in_ready       = !skid_valid_q;
  assign out_valid      = main_valid_q;
  assign out_wdata      = main_q.wdata;
  assign out_be         = main_q.be;
  assign out_misaligned = main_q.misaligned;
  assign out_trunc      = main_q.trunc;
  assign fault_count    = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_store_formatter.sv
// ============================================================================
// Module   : tb_store_formatter
// Purpose  : Directed self-checking bench for store_formatter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_formatter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  in_size;
  logic [2:0]  in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_wdata;
  logic [7:0]  out_be;
  logic        out_misaligned;
  logic        out_trunc;
  logic [7:0]  fault_count;

  // Narrow-counter instance shares all inputs; only its counter is observed.
  logic        s_in_ready;
  logic        s_out_valid;
  logic [63:0] s_out_wdata;
  logic [7:0]  s_out_be;
  logic        s_out_mis;
  logic        s_out_trunc;
  logic [1:0]  s_fault_count;

  int n_assert = 0;
  int n_fail   = 0;

  store_formatter #(.FAULT_CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_size(in_size), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wdata(out_wdata), .out_be(out_be),
    .out_misaligned(out_misaligned), .out_trunc(out_trunc),
    .fault_count(fault_count)
  );

  store_formatter #(.FAULT_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_size(in_size), .in_addr(in_addr),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_wdata(s_out_wdata), .out_be(s_out_be),
    .out_misaligned(s_out_mis), .out_trunc(s_out_trunc),
    .fault_count(s_fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sz, input logic [2:0] a, input logic [63:0] d);
    in_valid = v;
    in_size  = sz;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] wd, input logic [7:0] be,
                         input logic mis, input logic tr);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_wdata"}, out_wdata, wd);
    chk({tag, "_be"}, {56'd0, out_be}, {56'd0, be});
    chk({tag, "_mis"}, {63'd0, out_misaligned}, {63'd0, mis});
    chk({tag, "_trunc"}, {63'd0, out_trunc}, {63'd0, tr});
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 64'd0);
    step();
    step();
    reset = 1'b0;

    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_wdata", out_wdata, 64'd0);
    chk("rst_be", {56'd0, out_be}, 64'd0);
    chk("rst_mis", {63'd0, out_misaligned}, 64'd0);
    chk("rst_trunc", {63'd0, out_trunc}, 64'd0);
    chk("rst_fault", {56'd0, fault_count}, 64'd0);
    chk("rst_fault_sat", {62'd0, s_fault_count}, 64'd0);

    // Byte store into lane 3
    drive(1'b1, 2'b00, 3'd3, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    chk_out("byte", 64'h0000_0000_8000_0000, 8'h08, 1'b0, 1'b0);

    // Word store into upper half, not representable as signed word
    drive(1'b1, 2'b10, 3'd4, 64'h0000_0000_8000_0000);
    step();
    chk_out("word", 64'h8000_0000_0000_0000, 8'hF0, 1'b0, 1'b1);
    chk("word_fault_before", {56'd0, fault_count}, 64'd0);
    drive(1'b0, 2'b00, 3'd0, 64'd0);
    step();
    chk("word_fault_after", {56'd0, fault_count}, 64'd1);
    chk("word_fault_sat", {62'd0, s_fault_count}, 64'd1);
    chk("word_drained", {63'd0, out_valid}, 64'd0);

    // Misaligned half, then aligned double
    drive(1'b1, 2'b01, 3'd1, 64'h0000_0000_0000_1234);
    step();
    chk_out("half_mis", 64'h0000_0000_0000_1234, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 3'd0, 64'h0123_4567_89AB_CDEF);
    step();
    chk_out("double", 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b0);
    chk("half_fault", {56'd0, fault_count}, 64'd2);
    drive(1'b0, 2'b00, 3'd0, 64'd0);
    step();
    chk("double_fault", {56'd0, fault_count}, 64'd2);

    // Backpressure with A, B, C
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 3'd0, 64'h11);
    step();
    chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 2'b00, 3'd1, 64'h22);
    step();
    chk("bp_b_ready", {63'd0, in_ready}, 64'd0);
    chk_out("bp_hold_a", 64'h11, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 3'd2, 64'h33);
    step();
    chk_out("bp_stable_a", 64'h11, 8'h01, 1'b0, 1'b0);
    chk("bp_c_blocked", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    chk_out("bp_b", 64'h2200, 8'h02, 1'b0, 1'b0);
    chk("bp_ready_again", {63'd0, in_ready}, 64'd1);
    step();
    chk_out("bp_c", 64'h33_0000, 8'h04, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 3'd0, 64'd0);
    step();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    chk("bp_fault", {56'd0, fault_count}, 64'd2);

    // Five misaligned transfers back to back
    drive(1'b1, 2'b01, 3'd1, 64'h1);
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, 2'b00, 3'd0, 64'd0);
    step();
    chk("sat_fault_wide", {56'd0, fault_count}, 64'd7);
    chk("sat_fault_narrow", {62'd0, s_fault_count}, 64'd3);
    step();
    chk("sat_fault_hold", {62'd0, s_fault_count}, 64'd3);

    // Reset with main and skid both full
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 3'd0, 64'h44);
    step();
    drive(1'b1, 2'b00, 3'd1, 64'h55);
    step();
    chk("mid_skid_full", {63'd0, in_ready}, 64'd0);
    drive(1'b0, 2'b00, 3'd0, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_fault", {56'd0, fault_count}, 64'd0);
    chk("mid_fault_sat", {62'd0, s_fault_count}, 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 3'd0, 64'h0000_0000_7FFF_FFFF);
    step();
    chk_out("post_rst", 64'h0000_0000_7FFF_FFFF, 8'h0F, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 3'd0, 64'd0);
    step();
    chk("post_rst_drain", {63'd0, out_valid}, 64'd0);
    chk("post_rst_fault", {56'd0, fault_count}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_formatter.md
# store_formatter

Narrows a 64-bit register value for STURB/STURH/STURW/STUR and places it into the correct byte lanes of the 64-bit data-memory write port, with byte enables. It sits between the MEM-stage store path and data memory and is the inverse of the load-side sign extension. Each store also gets two checks:
- an alignment check;
- a truncation check: would sign-extending the narrowed value reproduce the original?

The block is a one-stage registered pipeline with a valid/ready handshake and a two-entry skid buffer.

## Interface
Parameters:
- FAULT_CNT_W, default 8: width of the saturating fault counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_data  in  64  register value to store.
- in_size  in  2  00 byte, 01 half, 10 word, 11 double.
- in_addr  in  3  low address bits (byte offset within the 64-bit word).
- out_valid  out  1  formatted write valid.
- out_ready  in  1  data memory accepts the write this cycle.
- out_wdata  out  64  lane-aligned write data.
- out_be  out  8  byte enables; bit i enables out_wdata[8i+7:8i].
- out_misaligned  out  1  request was misaligned; out_be forced to 0.
- out_trunc  out  1  value was not representable in the signed narrow width.
- fault_count  out  FAULT_CNT_W  count of accepted outputs with out_misaligned or out_trunc set; saturating.

## Operation
Sizing and alignment:
- nbytes = 1 << in_size.
- Misaligned when in_addr is not a multiple of nbytes: half with addr[0]≠0; word with addr[1:0]≠0; double with addr≠0.

Lane placement:
- narrow = in_data masked to its low 8·nbytes bits.
- wdata = narrow << (8·in_addr).
- be = ((1<<nbytes)−1) << in_addr, truncated to 8 bits.
- When misaligned: be = 0, wdata = narrow (not shifted), misaligned = 1.

Truncation check:
- trunc = 1 when in_data[63:8·nbytes] ≠ replication of in_data[8·nbytes−1].
- Double: trunc is always 0.
- trunc is a flag only; the write still proceeds with its enables.

Pipeline:
- Formatting is combinational on the input.
- Results are captured into the main output register, which drives out_*.
- A second skid register holds one extra entry when the main register is stalled.
- Order is strictly preserved: the main register always holds the oldest entry.

Handshake rules:
- Input transfer: in_valid && in_ready at the clock edge.
- Output transfer: out_valid && out_ready at the clock edge.
- in_ready = !skid_valid, driven from a register.

Register updates:
- Main empty, or main transferring this edge:
  - loads the skid entry if skid_valid;
  - otherwise loads the new input if accepted;
  - otherwise main_valid clears.
- A new input accepted while main is full and not transferring goes to skid.
- Main transferring while skid is full: skid moves to main, skid clears, and the new input (in_ready was 0) is not accepted.

fault_count:
- Increments on each output transfer with out_misaligned|out_trunc.
- Holds at 2^FAULT_CNT_W−1.

## Timing
- Latency: a request accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- Throughput: 1 per cycle while out_ready = 1.
- Reset values:
  - out_valid = 0, skid empty, in_ready = 1;
  - out_wdata = 0, out_be = 0, out_misaligned = 0, out_trunc = 0;
  - fault_count = 0.
- Reset mid-operation discards both held entries; no output transfer occurs on the reset edge.
- out_* stay stable while out_valid && !out_ready.
- Simultaneous input and output transfer with skid empty: main is replaced by the new entry, and out_valid stays 1.
- in_valid is ignored while in_ready = 0.
- Inputs are don't-care when in_valid = 0.

## Structure
- Shared package mem_pkg:
  - mem_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE);
  - a packed struct for the formatted entry {wdata, be, misaligned, trunc}.
- Sub-module store_lane_fmt: the combinational sizing, alignment, placement and truncation logic (size, addr, data → entry struct).
- The top level holds the main/skid registers, handshake logic and fault counter.

## Test plan
1. Byte store, data 0xFFFF_FFFF_FFFF_FF80, addr 3 → out_wdata 0x0000_0000_8000_0000, out_be 0x08, trunc 0, misaligned 0, one cycle after acceptance.
2. Word store, data 0x0000_0000_8000_0000, addr 4 → out_wdata 0x8000_0000_0000_0000, out_be 0xF0, trunc 1; fault_count increments by 1 on transfer.
3. Half store, addr 1, data 0x1234 → misaligned 1, out_be 0x00, out_wdata 0x1234; double store, addr 0 → out_be 0xFF, trunc 0.
4. Backpressure:
   - hold out_ready = 0 and present 3 back-to-back valid requests A, B, C;
   - A and B are accepted, and in_ready = 0 after B;
   - raise out_ready: outputs appear in order A, B, C with no loss or duplication.
5. Fault counter saturation:
   - FAULT_CNT_W = 2, five misaligned transfers → fault_count = 3 and stays at 3.
6. Reset mid-operation:
   - reset with main and skid full → next cycle out_valid 0, in_ready 1, fault_count 0;
   - a subsequent request emerges normally.
